dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one byte-masked read or write request
// at a time and answers with a one-cycle resp pulse LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx_p0;
    logic [3:0]        rmask_p0;
    logic [3:0]        wmask_p0;
    logic [31:0]       wdata_p0;
    logic              err_p0;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              req;
    logic              accept;
    logic [29:0]       word_off;
    logic              in_range;
    logic              unused_addr_bits;

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Word offset from the window base; an address below the base wraps to a huge offset.
    assign word_off         = dmem_addr[31:2] - BASE_ADDR[31:2];
    assign in_range         = {2'b00, word_off} < 32'(DEPTH_WORDS);
    assign req              = (|dmem_rmask) | (|dmem_wmask);
    assign accept           = (state == IDLE) && req;
    assign unused_addr_bits = ^dmem_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt   <= CNT_INIT;
                        state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Captured request: only the copy taken at acceptance drives the response.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0   <= word_off[AW-1:0];
            rmask_p0 <= dmem_rmask;
            wmask_p0 <= dmem_wmask;
            wdata_p0 <= dmem_wdata;
            err_p0   <= !in_range || ((|dmem_rmask) && (|dmem_wmask));
        end
    end

    // Reset forces state to IDLE asynchronously, so a write pending in RESP is dropped.
    always_ff @(posedge clk) begin
        if ((state == RESP) && !err_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_p0[b]) mem[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
            end
        end
    end

    assign dmem_resp  = (state == RESP);
    assign dmem_err   = dmem_resp && err_p0;
    assign dmem_rdata = (dmem_resp && !err_p0) ? (mem[idx_p0] & lane_mask(rmask_p0)) : 32'd0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic [31:0] addr2, wd2, rd2;
    logic [3:0]  rm2, wm2;
    logic        resp2, err2, busy2;

    logic [31:0] addr1, wd1, rd1;
    logic [3:0]  rm1, wm1;
    logic        resp1, err1, busy1;

    int n_vec = 0;
    int n_bad = 0;

    dmem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr2), .dmem_rmask(rm2), .dmem_wmask(wm2),
        .dmem_wdata(wd2), .dmem_rdata(rd2), .dmem_resp(resp2), .dmem_err(err2), .busy(busy2)
    );

    dmem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr1), .dmem_rmask(rm1), .dmem_wmask(wm1),
        .dmem_wdata(wd1), .dmem_rdata(rd1), .dmem_resp(resp1), .dmem_err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int sel, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
        if (sel == 1) begin
            addr1 = a; rm1 = rm; wm1 = wm; wd1 = wd;
        end else begin
            addr2 = a; rm2 = rm; wm2 = wm; wd2 = wd;
        end
    endtask

    function automatic logic cur_resp(input int sel);
        return (sel == 1) ? resp1 : resp2;
    endfunction

    // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic req(input int sel, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        logic got;
        logic [31:0] rd;
        logic er;
        drv(sel, a, rm, wm, wd);
        @(posedge clk);
        #1 drv(sel, 32'h1234_5670, 4'b0000, 4'b0000, 32'h5555_5555);
        n = 0;
        got = 1'b0;
        rd = 32'd0;
        er = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (cur_resp(sel)) begin
                got = 1'b1;
                rd = (sel == 1) ? rd1 : rd2;
                er = (sel == 1) ? err1 : err2;
            end
        end
        chk({tag, " latency"}, 32'(n), (sel == 1) ? 32'd1 : 32'd2);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, " resp_drop"}, {31'd0, cur_resp(sel)}, 32'd0);
    endtask

    initial begin
        int first, second, cnt;
        rst_n = 1'b0;
        drv(1, 32'd0, 4'b0000, 4'b0000, 32'd0);
        drv(2, 32'd0, 4'b0000, 4'b0000, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst resp", {31'd0, resp2}, 32'd0);
        chk("rst err", {31'd0, err2}, 32'd0);
        chk("rst rdata", rd2, 32'd0);
        chk("rst busy", {31'd0, busy2}, 32'd0);
        rst_n = 1'b1;

        req(2, 32'h6000_0010, 4'b0000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr full");
        req(2, 32'h6000_0010, 4'b1111, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd full");
        req(2, 32'h6000_0012, 4'b0000, 4'b0100, 32'h00AA_0000, 32'h0, 1'b0, "wr byte2");
        req(2, 32'h6000_0010, 4'b1111, 4'b0000, 32'h0, 32'hDEAA_BEEF, 1'b0, "rd merged");
        req(2, 32'h6000_0010, 4'b0011, 4'b0000, 32'h0, 32'h0000_BEEF, 1'b0, "rd low half");

        req(2, 32'h5FFF_FFFC, 4'b1111, 4'b0000, 32'h0, 32'h0, 1'b1, "err below");
        req(2, 32'h6000_1000, 4'b1111, 4'b0000, 32'h0, 32'h0, 1'b1, "err above");
        req(2, 32'h6000_0FFC, 4'b0000, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, "wr last word");
        req(2, 32'h6000_0FFC, 4'b1111, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, "rd last word");
        req(2, 32'h6000_0010, 4'b0001, 4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b1, "err both masks");
        req(2, 32'h6000_0010, 4'b1111, 4'b0000, 32'h0, 32'hDEAA_BEEF, 1'b0, "rd after errs");

        // Request held continuously: responses at negedges 2 and 5.
        drv(2, 32'h6000_0010, 4'b1111, 4'b0000, 32'h0);
        first = 0; second = 0; cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (resp2) begin
                cnt++;
                if (first == 0) first = i; else second = i;
            end
            if (i == 5) drv(2, 32'h0, 4'b0000, 4'b0000, 32'h0);
        end
        chk("hold count", 32'(cnt), 32'd2);
        chk("hold first", 32'(first), 32'd2);
        chk("hold spacing", 32'(second - first), 32'd3);

        // Reset during WAIT abandons the write.
        drv(2, 32'h6000_0010, 4'b0000, 4'b1111, 32'h1234_5678);
        @(posedge clk);
        #1 drv(2, 32'h0, 4'b0000, 4'b0000, 32'h0);
        @(negedge clk);
        chk("wait busy", {31'd0, busy2}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", {31'd0, busy2}, 32'd0);
        chk("mid rst resp", {31'd0, resp2}, 32'd0);
        chk("mid rst rdata", rd2, 32'd0);
        chk("mid rst err", {31'd0, err2}, 32'd0);
        @(negedge clk);
        chk("in rst resp", {31'd0, resp2}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp2) cnt++;
        end
        chk("post rst no resp", 32'(cnt), 32'd0);
        req(2, 32'h6000_0010, 4'b1111, 4'b0000, 32'h0, 32'hDEAA_BEEF, 1'b0, "rd after rst");

        // LATENCY=1 instance.
        req(1, 32'h6000_0000, 4'b0000, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, "l1 wr");
        req(1, 32'h6000_0000, 4'b1100, 4'b0000, 32'h0, 32'h1122_0000, 1'b0, "l1 rd hi");
        drv(1, 32'h6000_0000, 4'b1111, 4'b0000, 32'h0);
        first = 0; second = 0; cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (resp1) begin
                cnt++;
                chk("l1 b2b rdata", rd1, 32'h1122_3344);
                if (first == 0) first = i; else second = i;
            end
            if (i == 3) drv(1, 32'h0, 4'b0000, 4'b0000, 32'h0);
        end
        chk("l1 b2b count", 32'(cnt), 32'd2);
        chk("l1 b2b first", 32'(first), 32'd1);
        chk("l1 b2b spacing", 32'(second - first), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
